// File: rtl/i2c_controller_tx.sv
// Write-only I2C controller: START, address+W, streamed data bytes with ACK checks, STOP.
// Open-drain pads are driven through the *_oe outputs; SCL stretching is honoured.
module i2c_controller_tx #(
   parameter int             CLK_DIV         = 30,
   parameter logic [6:0]     I2C_TARGET_ADDR = 7'h66
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i2c_scl_i,
   input  logic       i2c_sda_i,
   output logic       i2c_scl_o,
   output logic       i2c_scl_oe,
   output logic       i2c_sda_o,
   output logic       i2c_sda_oe,
   input  logic [7:0] tx_byte_data_i,
   input  logic       tx_byte_valid_i,
   output logic       tx_byte_ready_o,
   output logic       busy_o,
   output logic       nack_o
);

   // state    | meaning
   // IDLE     | bus free, accepting a byte
   // START    | SDA falls while SCL high (2 quarters)
   // ADDR     | shifting {addr, W} MSB first
   // ADDR_ACK | SDA released, sample target ACK
   // DATA     | shifting latched byte MSB first
   // DATA_ACK | SDA released, sample ACK, optionally take next byte
   // STOP     | SDA rises while SCL high, then bus free
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK, ST_STOP
   } state_t;

   localparam int         CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [7:0] ADDR_BYTE = {I2C_TARGET_ADDR, 1'b0};

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    byte_q, byte_d;
   logic          nack_q, nack_d;
   logic          scl_pull, sda_pull;
   logic          ready_c;
   logic          qtr_end, stretch_ok, hold;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         nack_q  <= nack_d;
      end
   end

   // Pad drive decode: bits hold SCL low in Q0/Q1, SDA changes with the Q0 entry.
   always_comb begin
      scl_pull = 1'b0;
      sda_pull = 1'b0;
      unique case (state_q)
         ST_START: sda_pull = 1'b1;
         ST_ADDR: begin
            scl_pull = !qtr_q[1];
            sda_pull = !ADDR_BYTE[bit_q];
         end
         ST_DATA: begin
            scl_pull = !qtr_q[1];
            sda_pull = !byte_q[bit_q];
         end
         ST_ADDR_ACK, ST_DATA_ACK: scl_pull = !qtr_q[1];
         ST_STOP: begin
            scl_pull = (qtr_q == 2'd0);
            sda_pull = !qtr_q[1];
         end
         default: ;
      endcase
   end

   // A target may stretch only where SCL is released; START and the final STOP quarter are exempt.
   assign stretch_ok = (state_q == ST_ADDR) || (state_q == ST_ADDR_ACK) ||
                       (state_q == ST_DATA) || (state_q == ST_DATA_ACK) ||
                       ((state_q == ST_STOP) && (qtr_q != 2'd3));
   assign hold    = stretch_ok && !scl_pull && (cnt_q == '0) && !i2c_scl_i;
   assign qtr_end = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      nack_d  = 1'b0;
      ready_c = 1'b0;

      if (state_q != ST_IDLE) begin
         if (hold) begin
            cnt_d = cnt_q;
         end else if (qtr_end) begin
            cnt_d = '0;
            qtr_d = qtr_q + 2'd1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
            cnt_d   = '0;
            qtr_d   = '0;
            if (tx_byte_valid_i) begin
               byte_d  = tx_byte_data_i;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (qtr_end && qtr_q == 2'd1) begin
               qtr_d   = '0;
               bit_d   = 3'd7;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (qtr_end && qtr_q == 2'd3) begin
               if (bit_q == 3'd0) state_d = ST_ADDR_ACK;
               else               bit_d   = bit_q - 3'd1;
            end
         end
         ST_ADDR_ACK: begin
            if (qtr_end && qtr_q == 2'd3) begin
               if (!i2c_sda_i) begin
                  bit_d   = 3'd7;
                  state_d = ST_DATA;
               end else begin
                  nack_d  = 1'b1;
                  state_d = ST_STOP;
               end
            end
         end
         ST_DATA: begin
            if (qtr_end && qtr_q == 2'd3) begin
               if (bit_q == 3'd0) state_d = ST_DATA_ACK;
               else               bit_d   = bit_q - 3'd1;
            end
         end
         ST_DATA_ACK: begin
            if (qtr_end && qtr_q == 2'd3) begin
               if (i2c_sda_i) begin
                  nack_d  = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  ready_c = 1'b1;
                  if (tx_byte_valid_i) begin
                     byte_d  = tx_byte_data_i;
                     bit_d   = 3'd7;
                     state_d = ST_DATA;
                  end else begin
                     state_d = ST_STOP;
                  end
               end
            end
         end
         ST_STOP: begin
            if (qtr_end && qtr_q == 2'd3) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign i2c_scl_o       = 1'b0;
   assign i2c_sda_o       = 1'b0;
   assign i2c_scl_oe      = scl_pull;
   assign i2c_sda_oe      = sda_pull;
   assign tx_byte_ready_o = ready_c & rst_n;
   assign busy_o          = (state_q != ST_IDLE);
   assign nack_o          = nack_q;

endmodule

// File: tb/tb_i2c_controller_tx.sv
// Directed bench for i2c_controller_tx with a bus-level target model that ACKs,
// decodes START/STOP and bytes, and can stretch SCL.
module tb_i2c_controller_tx;
   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n    = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       scl_oe, sda_oe, scl_o, sda_o;
   logic       tx_ready, busy, nack;

   logic       stretch = 1'b0;
   logic       ack_drv = 1'b0;
   logic       ack_en  = 1'b1;
   wire        scl_line = !(scl_oe || stretch);
   wire        sda_line = !(sda_oe || ack_drv);

   int n_checks = 0;
   int n_fail   = 0;

   i2c_controller_tx #(.CLK_DIV(CLK_DIV), .I2C_TARGET_ADDR(7'h66)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i2c_scl_i       (scl_line),
      .i2c_sda_i       (sda_line),
      .i2c_scl_o       (scl_o),
      .i2c_scl_oe      (scl_oe),
      .i2c_sda_o       (sda_o),
      .i2c_sda_oe      (sda_oe),
      .tx_byte_data_i  (tx_data),
      .tx_byte_valid_i (tx_valid),
      .tx_byte_ready_o (tx_ready),
      .busy_o          (busy),
      .nack_o          (nack)
   );

   // Target model, sampled on the falling clock edge.
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   int         bitcnt = 0, rise_cnt = 0, start_cnt = 0, stop_cnt = 0, nack_cnt = 0;
   logic [7:0] shreg = 8'h00;
   logic [7:0] rx_q[$];
   logic       stretch_arm = 1'b0;
   int         stretch_at = 0, st_phase = 0, st_left = 0;

   always @(negedge clk) begin
      if (nack) nack_cnt++;
      if (stretch_arm) begin
         case (st_phase)
            0: if (rise_cnt == stretch_at && !scl_line) begin stretch = 1'b1; st_phase = 1; end
            1: if (!scl_oe) begin st_phase = 2; st_left = 19; end
            2: if (st_left == 0) begin stretch = 1'b0; st_phase = 3; end else st_left--;
            default: ;
         endcase
      end
      if (scl_line && prev_scl && prev_sda && !sda_line) begin
         start_cnt++;
         bitcnt = 0;
      end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
         stop_cnt++;
         bitcnt  = 0;
         ack_drv = 1'b0;
      end else if (scl_line && !prev_scl) begin
         rise_cnt++;
         if (bitcnt < 8) begin
            shreg = {shreg[6:0], sda_line};
            bitcnt++;
            if (bitcnt == 8) rx_q.push_back(shreg);
         end else if (bitcnt == 8) begin
            bitcnt = 9;
         end
      end else if (!scl_line && prev_scl) begin
         if (bitcnt == 8 && ack_en) ack_drv = 1'b1;
         else if (bitcnt == 9) begin ack_drv = 1'b0; bitcnt = 0; end
      end
      prev_scl = scl_line;
      prev_sda = sda_line;
   end

   function automatic logic [7:0] rx_at(int k);
      if (k < rx_q.size()) return rx_q[k];
      return 8'hxx;
   endfunction

   // Streams nb bytes, counting busy cycles and accepted handshakes until busy drops.
   task automatic run_txn(input int nb, input logic [7:0] b0, b1, b2,
                          output int busy_cyc, output int hs, output bit timed_out);
      logic [7:0] bytes [3];
      int  idx;
      bit  seen, pend;
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
      busy_cyc = 0; hs = 0; idx = 0; seen = 0; pend = 0; timed_out = 1;
      @(negedge clk); #1;
      tx_data  = bytes[0];
      tx_valid = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (tx_valid && tx_ready) begin hs++; idx++; pend = 1; end
         @(negedge clk); #1;
         if (pend) begin
            if (idx < nb) tx_data = bytes[idx];
            else          tx_valid = 1'b0;
            pend = 0;
         end
         if (busy) begin
            busy_cyc++;
            seen = 1;
         end else if (seen) begin
            timed_out = 0;
            break;
         end
      end
      tx_valid = 1'b0;
      n_checks++;
      if (timed_out) begin
         n_fail++;
         $display("FAIL txn_timeout: busy_cycles=%0d, required completion within 3000 cycles", busy_cyc);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (scl_oe !== 1'b0)   begin n_fail++; $display("FAIL rst_scl_oe: got %b want 0", scl_oe); end
      n_checks++; if (sda_oe !== 1'b0)   begin n_fail++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
      n_checks++; if (scl_o !== 1'b0)    begin n_fail++; $display("FAIL rst_scl_o: got %b want 0", scl_o); end
      n_checks++; if (sda_o !== 1'b0)    begin n_fail++; $display("FAIL rst_sda_o: got %b want 0", sda_o); end
      n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", tx_ready); end
      n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (nack !== 1'b0)     begin n_fail++; $display("FAIL rst_nack: got %b want 0", nack); end
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", tx_ready); end
   endtask

   task automatic test_single_byte();
      int base, st0, sp0, nk0, bc, hs;
      bit to;
      base = rx_q.size(); st0 = start_cnt; sp0 = stop_cnt; nk0 = nack_cnt;
      run_txn(1, 8'hA5, 8'h00, 8'h00, bc, hs, to);
      n_checks++; if (bc !== 312) begin n_fail++; $display("FAIL single_busy: got %0d want 312", bc); end
      n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL single_handshakes: got %0d want 1", hs); end
      n_checks++; if (rx_q.size() - base !== 2) begin n_fail++; $display("FAIL single_nbytes: got %0d want 2", rx_q.size() - base); end
      n_checks++; if (rx_at(base) !== 8'hCC) begin n_fail++; $display("FAIL single_addr: got %h want cc", rx_at(base)); end
      n_checks++; if (rx_at(base + 1) !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", rx_at(base + 1)); end
      n_checks++; if (start_cnt - st0 !== 1) begin n_fail++; $display("FAIL single_starts: got %0d want 1", start_cnt - st0); end
      n_checks++; if (stop_cnt - sp0 !== 1) begin n_fail++; $display("FAIL single_stops: got %0d want 1", stop_cnt - sp0); end
      n_checks++; if (nack_cnt !== nk0) begin n_fail++; $display("FAIL single_nack: got %0d pulses want 0", nack_cnt - nk0); end
      n_checks++; if ({scl_oe, sda_oe, tx_ready} !== 3'b001) begin n_fail++; $display("FAIL single_idle_after: got %b want 001", {scl_oe, sda_oe, tx_ready}); end
   endtask

   task automatic test_back_to_back();
      int base, st0, sp0, bc, hs;
      bit to;
      base = rx_q.size(); st0 = start_cnt; sp0 = stop_cnt;
      run_txn(3, 8'h11, 8'h22, 8'h33, bc, hs, to);
      n_checks++; if (bc !== 600) begin n_fail++; $display("FAIL burst_busy: got %0d want 600", bc); end
      n_checks++; if (hs !== 3) begin n_fail++; $display("FAIL burst_handshakes: got %0d want 3", hs); end
      n_checks++; if (rx_q.size() - base !== 4) begin n_fail++; $display("FAIL burst_nbytes: got %0d want 4", rx_q.size() - base); end
      n_checks++; if (rx_at(base) !== 8'hCC) begin n_fail++; $display("FAIL burst_addr: got %h want cc", rx_at(base)); end
      n_checks++; if (rx_at(base + 1) !== 8'h11) begin n_fail++; $display("FAIL burst_b0: got %h want 11", rx_at(base + 1)); end
      n_checks++; if (rx_at(base + 2) !== 8'h22) begin n_fail++; $display("FAIL burst_b1: got %h want 22", rx_at(base + 2)); end
      n_checks++; if (rx_at(base + 3) !== 8'h33) begin n_fail++; $display("FAIL burst_b2: got %h want 33", rx_at(base + 3)); end
      n_checks++; if (start_cnt - st0 !== 1) begin n_fail++; $display("FAIL burst_starts: got %0d want 1", start_cnt - st0); end
      n_checks++; if (stop_cnt - sp0 !== 1) begin n_fail++; $display("FAIL burst_stops: got %0d want 1", stop_cnt - sp0); end
   endtask

   task automatic test_addr_nack();
      int base, sp0, nk0, bc, hs;
      bit to;
      ack_en = 1'b0;
      base = rx_q.size(); sp0 = stop_cnt; nk0 = nack_cnt;
      run_txn(1, 8'h77, 8'h00, 8'h00, bc, hs, to);
      n_checks++; if (bc !== 168) begin n_fail++; $display("FAIL nack_busy: got %0d want 168", bc); end
      n_checks++; if (nack_cnt - nk0 !== 1) begin n_fail++; $display("FAIL nack_pulses: got %0d want 1", nack_cnt - nk0); end
      n_checks++; if (stop_cnt - sp0 !== 1) begin n_fail++; $display("FAIL nack_stops: got %0d want 1", stop_cnt - sp0); end
      n_checks++; if (rx_q.size() - base !== 1) begin n_fail++; $display("FAIL nack_nbytes: got %0d want 1", rx_q.size() - base); end
      n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL nack_ready_after: got %b want 1", tx_ready); end
      ack_en = 1'b1;
   endtask

   task automatic test_clock_stretch();
      int base, bc, hs;
      bit to;
      base = rx_q.size();
      stretch_at  = rise_cnt + 12;
      st_phase    = 0;
      stretch_arm = 1'b1;
      run_txn(1, 8'h96, 8'h00, 8'h00, bc, hs, to);
      stretch_arm = 1'b0;
      n_checks++; if (st_phase !== 3) begin n_fail++; $display("FAIL stretch_applied: phase %0d want 3", st_phase); end
      n_checks++; if (bc !== 332) begin n_fail++; $display("FAIL stretch_busy: got %0d want 332", bc); end
      n_checks++; if (rx_at(base) !== 8'hCC) begin n_fail++; $display("FAIL stretch_addr: got %h want cc", rx_at(base)); end
      n_checks++; if (rx_at(base + 1) !== 8'h96) begin n_fail++; $display("FAIL stretch_data: got %h want 96", rx_at(base + 1)); end
   endtask

   task automatic test_reset_mid_txn();
      int  base_rise, sp0, base, bc, hs;
      bit  found, to;
      base_rise = rise_cnt;
      @(negedge clk); #1;
      tx_data = 8'h5A; tx_valid = 1'b1;
      @(negedge clk); #1;
      tx_valid = 1'b0;
      found = 0;
      for (int c = 0; c < 1000; c++) begin
         if (rise_cnt == base_rise + 13 && !scl_line) begin found = 1; break; end
         @(negedge clk); #1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL midrst_reach_bit5: rises=%0d want %0d", rise_cnt - base_rise, 13); end
      @(negedge clk); #1;
      sp0 = stop_cnt;
      rst_n = 1'b0;
      @(negedge clk); #1;
      n_checks++; if ({scl_oe, sda_oe} !== 2'b00) begin n_fail++; $display("FAIL midrst_lines: got %b want 00", {scl_oe, sda_oe}); end
      n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", tx_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after: got %b want 1", tx_ready); end
      n_checks++; if (stop_cnt !== sp0) begin n_fail++; $display("FAIL midrst_no_stop: got %0d stops want 0", stop_cnt - sp0); end
      base = rx_q.size();
      run_txn(1, 8'h81, 8'h00, 8'h00, bc, hs, to);
      n_checks++; if (bc !== 312) begin n_fail++; $display("FAIL midrst_retry_busy: got %0d want 312", bc); end
      n_checks++; if (rx_at(base) !== 8'hCC) begin n_fail++; $display("FAIL midrst_retry_addr: got %h want cc", rx_at(base)); end
      n_checks++; if (rx_at(base + 1) !== 8'h81) begin n_fail++; $display("FAIL midrst_retry_data: got %h want 81", rx_at(base + 1)); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_addr_nack();
      test_clock_stretch();
      test_reset_mid_txn();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_controller_tx.md
# i2c_controller_tx

I2C controller (bus initiator) that performs write-only transactions to a single 7-bit target address. Bytes come from fabric logic through a valid/ready stream, and the block generates START, address+W, data bytes, ACK checks and STOP on open-drain SCL/SDA. It is the counterpart of our `i2c_target` receive path. It lets the FPGA drive external I2C peripherals, and it provides loopback stimulus for the target.

## Interface
Parameters:
- `CLK_DIV`, default 30: clk cycles per SCL quarter-period. SCL period = 4*CLK_DIV cycles. Legal values ≥ 2.
- `I2C_TARGET_ADDR`, default 'h66: 7-bit target address. The R/W bit is always 0.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `i2c_scl_i`  in  1  sampled SCL pad, used for clock-stretch detection
- `i2c_sda_i`  in  1  sampled SDA pad, used for ACK sampling
- `i2c_scl_o`  out  1  constant 0
- `i2c_scl_oe`  out  1  1 = pull SCL low
- `i2c_sda_o`  out  1  constant 0
- `i2c_sda_oe`  out  1  1 = pull SDA low
- `tx_byte_data_i`  in  8  byte to write
- `tx_byte_valid_i`  in  1  byte available
- `tx_byte_ready_o`  out  1  byte accepted when valid && ready
- `busy_o`  out  1  transaction in progress
- `nack_o`  out  1  one-cycle pulse when the target NACKs

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- Quarter counter counts 0..CLK_DIV-1. Every data/ACK bit uses four quarters:
  - Q0: SCL pulled low; SDA updated at the first cycle of Q0.
  - Q1: SCL low.
  - Q2, Q3: SCL released.
- Bit data: bit=0 → sda_oe=1; bit=1 or ACK slot → sda_oe=0. Bits are sent MSB first.
- IDLE:
  - Both oe=0, ready=1, busy=0.
  - On handshake: latch the byte, go to START, ready=0, busy=1 from the next cycle.
- START:
  - 2 quarters with SCL released and sda_oe=1 (SDA falls while SCL is high).
  - Then ADDR.
- ADDR: 8 bits of {I2C_TARGET_ADDR, 1'b0}, then ADDR_ACK.
- ADDR_ACK / DATA_ACK:
  - SDA released.
  - i2c_sda_i sampled on the last cycle of Q3; 0 = ACK.
- ADDR_ACK outcome:
  - ACK → DATA with the latched byte.
  - NACK → nack_o pulse, discard the latched byte, go to STOP.
- DATA: 8 bits, then DATA_ACK.
- DATA_ACK outcome:
  - NACK → nack_o pulse, STOP.
  - ACK → ready=1 for exactly the last Q3 cycle. If valid is high on that cycle, latch the new byte and go to DATA (no repeated START). Otherwise go to STOP.
- STOP, 4 quarters:
  - Q0: SCL low, SDA low.
  - Q1: SCL released, SDA low.
  - Q2: SDA released (rising edge while SCL high).
  - Q3: bus free.
  - Then IDLE.
- Clock stretching:
  - In any quarter where SCL is released, the quarter counter holds at 0 until i2c_scl_i reads 1. Counting starts on the cycle after SCL reads high.
  - Stretching never occurs in START or STOP Q3.

## Timing
- Reset values: scl_oe=0, sda_oe=0, scl_o=0, sda_o=0, ready=0, busy=0, nack=0, state=IDLE. ready rises on the first cycle after rst_n=1.
- Reset mid-transaction releases both lines on the next clock. No STOP is generated. The latched byte is lost.
- Single-byte transaction without stretching: busy_o high for exactly 78*CLK_DIV cycles (2 START + 36 ADDR/ACK + 36 DATA/ACK + 4 STOP quarters).
- Each additional burst byte adds 36*CLK_DIV cycles.
- An address-NACK transaction lasts 42*CLK_DIV cycles.
- nack_o is asserted for exactly the one cycle that follows the sampling cycle.
- The block never accepts data while busy, except on the DATA_ACK ready cycle.
- valid with ready=0 has no effect. The data must be held by the source.

## Test plan
- CLK_DIV=4, target model ACKs everything, send 0xA5 → SDA bits on SCL rising edges are 0xCC then 0xA5. START precedes them and STOP follows. busy_o is high for 312 cycles. nack_o never pulses.
- Burst: valid held with 0x11, 0x22, 0x33 → one START, address 0xCC, three data bytes, one STOP. ready pulses 3 times. busy_o is high for (78+72)*4 = 600 cycles.
- No target (SDA pulled high) → nack_o pulses once after ADDR_ACK, followed by STOP. busy_o is high for 168 cycles and ready returns to 1.
- Target stretches SCL low for 20 cycles after the 3rd data bit → the transaction extends by exactly 20 cycles and all bit values are unchanged.
- Assert rst_n=0 during the 5th data bit → both oe are 0 on the next cycle. ready=0 while in reset. After release: idle, a new transaction succeeds.
- Loopback with `i2c_target` (address 'h66), send 0x3C → the target reports 0x3C with rx valid for one pulse, and the 7-seg display inputs show 3/C.
